// File: rtl/mem_arbiter.sv
// mem_arbiter: three-way arbiter sharing one memory read/write port between
// screen refresh (port 0, fixed priority), CPU (port 1) and GPU (port 2),
// with ports 1/2 served round-robin.
// Ports: clk/reset (async, active high); req_read/req_write/req_idx/req_wbyte
// per-port requests; rd_ack/wr_done/rd_byte/gnt back to the requesters;
// mem_* drive the single-port memory.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req_read,
  input  logic [2:0]            req_write,
  input  logic [3*ADDR_W-1:0]   req_idx,
  input  logic [3*DATA_W-1:0]   req_wbyte,
  output logic [2:0]            rd_ack,
  output logic [2:0]            wr_done,
  output logic [DATA_W-1:0]     rd_byte,
  output logic [2:0]            gnt,
  output logic                  mem_read,
  output logic [ADDR_W-1:0]     mem_read_idx,
  input  logic [DATA_W-1:0]     mem_read_byte,
  input  logic                  mem_read_ack,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_write_idx,
  output logic [DATA_W-1:0]     mem_write_byte
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, state_n;
  logic [2:0] pend, win;
  logic [1:0] wid;
  logic rr;
  logic op_w;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] wbyte;
  // rr = 0 favours port 1, rr = 1 favours port 2 when both are pending
  always_comb begin
    pend = req_read | req_write;
    win = pend[0] ? 3'b001 : (pend[1] && (!pend[2] || !rr)) ? 3'b010 : pend[2] ? 3'b100 : 3'b000;
    wid = win[2] ? 2'd2 : win[1] ? 2'd1 : 2'd0;
    state_n = state == IDLE ? (!(|win) ? IDLE : |(req_write & win) ? WRITE : READ) :
              state == WRITE ? DONE :
              state == READ ? (mem_read_ack ? DONE : READ) : IDLE;
    mem_read = state == READ && !mem_read_ack;
    mem_read_idx = state == READ ? idx : '0;
    mem_write = state == WRITE;
    mem_write_idx = state == WRITE ? idx : '0;
    mem_write_byte = state == WRITE ? wbyte : '0;
    rd_ack = (state == DONE && !op_w) ? gnt : 3'b000;
    wr_done = (state == DONE && op_w) ? gnt : 3'b000;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      rr <= 1'b0;
      op_w <= 1'b0;
      idx <= '0;
      wbyte <= '0;
      rd_byte <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |win) begin
        gnt <= win;
        op_w <= |(req_write & win);
        idx <= req_idx[wid*ADDR_W +: ADDR_W];
        wbyte <= req_wbyte[wid*DATA_W +: DATA_W];
        // a port-0 win leaves the round-robin pointer alone
        if (!win[0]) rr <= win[1];
      end
      if (state == DONE) gnt <= '0;
      if (state == READ && mem_read_ack) rd_byte <= mem_read_byte;
    end
  end
endmodule
